// File: rtl/piso_tx_ctrl_pkg.sv
// Shared state encoding and sizing helper for the PISO transmit sequencer.
package piso_tx_ctrl_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StShift  = 3'd2,
    StParity = 3'd3,
    StGap    = 3'd4
  } state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_ctrl_cnt.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module piso_tx_ctrl_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_tx_ctrl.sv
// Valid/ready to PISO sequencer: load, shift WIDTH bits, optional parity cycle, idle gap.
// Optional feature: define PARITY_EN to add an even-parity cycle after the data bits.
module piso_tx_ctrl
  import piso_tx_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             piso_ld,
  output logic [WIDTH-1:0] piso_in,
  output logic             frame,
  output logic             done,
  output logic             par_valid,
  output logic             par_bit
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned GapW = cnt_width(GAP_CYCLES);
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [CntW-1:0]   bit_cnt;
  logic              bit_zero;

  piso_tx_ctrl_cnt #(
    .W (CntW)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == StLoad),
    .load_val (BitLast),
    .dec      (state_q == StShift),
    .cnt      (bit_cnt),
    .zero     (bit_zero)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (in_valid) begin
          hold_d  = in_data;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StShift;
      StShift: begin
        if (bit_zero) begin
`ifdef PARITY_EN
          state_d = StParity;
`else
          state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
`endif
        end
      end
      StParity: state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decode from registered state only; nothing combinational from in_valid.
  always_comb begin
    in_ready = (state_q == StIdle);
    piso_ld  = (state_q == StLoad);
    piso_in  = hold_q;
    frame    = (state_q == StShift);
`ifdef PARITY_EN
    done      = (state_q == StParity);
    par_valid = (state_q == StParity);
    par_bit   = (state_q == StParity) && (^hold_q);
`else
    done      = (state_q == StShift) && bit_zero;
    par_valid = 1'b0;
    par_bit   = 1'b0;
`endif
  end

endmodule
